// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared types and TMDS constants for the HDMI period sequencer.
package hdmi_pkg;
  typedef enum logic [1:0] {CTRL, PREAMBLE, GUARD, VIDEO} seq_state_t;
  localparam logic [3:0] CTL_VIDEO_PRE = 4'b0001;
  localparam logic [9:0] GB_BLUE = 10'b1011001100;
  localparam logic [9:0] GB_GREEN = 10'b0100110011;
  localparam logic [9:0] GB_RED = 10'b1011001100;
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    return c == 2'b00 ? CTRL_TOKEN_00 :
           c == 2'b01 ? CTRL_TOKEN_01 :
           c == 2'b10 ? CTRL_TOKEN_10 : CTRL_TOKEN_11;
  endfunction
endpackage

// File: rtl/hdmi_period_sequencer_pipe_delay.sv
// pipe_delay: synchronous-clear shift register; tap_o is the MSB one stage before the output.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             tap_o,
  output logic [WIDTH-1:0] dout_o
);
  logic [WIDTH-1:0] sr_q [DEPTH];
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end
  assign tap_o = sr_q[DEPTH-2][WIDTH-1];
  assign dout_o = sr_q[DEPTH-1];
endmodule

// File: rtl/hdmi_period_sequencer.sv
// hdmi_period_sequencer: steps TMDS encoders through control, preamble, guard and video periods.
// Define HDMI_PREAMBLE_EN for HDMI periods; otherwise plain DVI with identical latency.
module hdmi_period_sequencer
  import hdmi_pkg::*;
#(
  parameter int PIX_W = 24,
  parameter int PREAMBLE_LEN = 8,
  parameter int GUARD_LEN = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             active_in,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [PIX_W-1:0] pix_in,
  output logic             ve_out,
  output logic [PIX_W-1:0] pix_out,
  output logic [1:0]       ctrl_blue_out,
  output logic [1:0]       ctrl_green_out,
  output logic [1:0]       ctrl_red_out,
  output logic             guard_out,
  output logic             err_out
);
  localparam int LATENCY = 1 + PREAMBLE_LEN + GUARD_LEN;
  localparam int DW = PIX_W + 3;
  logic [DW-1:0] dl_out;
  logic act_d, act_tap;
  seq_state_t state_q, state_d;
  pipe_delay #(.WIDTH(DW), .DEPTH(LATENCY)) u_dl (
    .clk_i(clk_in),
    .rst_n_i(rst_n_in),
    .din_i({active_in, vs_in, hs_in, pix_in}),
    .tap_o(act_tap),
    .dout_o(dl_out)
  );
  assign {act_d, ctrl_blue_out, pix_out} = dl_out;
`ifdef HDMI_PREAMBLE_EN
  localparam int CW = $clog2(PREAMBLE_LEN > GUARD_LEN ? PREAMBLE_LEN : GUARD_LEN) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic active_q, err_q, err_d, ve_q, guard_q, rise;
  logic [3:0] ctl_q;
  assign rise = active_in & ~active_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (state_q)
      CTRL: begin
        if (act_d) state_d = VIDEO;
        else if (rise) begin
          state_d = PREAMBLE;
          cnt_d = CW'(PREAMBLE_LEN - 1);
        end
      end
      PREAMBLE: begin
        if (act_d) begin
          state_d = VIDEO;
          err_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = GUARD;
          cnt_d = CW'(GUARD_LEN - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      GUARD: begin
        if (act_d) begin
          state_d = VIDEO;
          err_d = 1'b1;
        end else if (cnt_q == '0) state_d = VIDEO;
        else cnt_d = cnt_q - 1'b1;
      end
      VIDEO: state_d = act_d ? VIDEO : CTRL;
      default: state_d = CTRL;
    endcase
    if (rise && (state_q != CTRL || act_d)) err_d = 1'b1;
  end
  // ve looks one stage ahead so it follows act_d without a cycle of lag on exit
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= CTRL;
      cnt_q <= '0;
      active_q <= 1'b1;
      err_q <= 1'b0;
      ve_q <= 1'b0;
      guard_q <= 1'b0;
      ctl_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      active_q <= active_in;
      err_q <= err_d;
      ve_q <= (state_d == VIDEO) & act_tap;
      guard_q <= state_d == GUARD;
      ctl_q <= state_d == PREAMBLE ? CTL_VIDEO_PRE : 4'b0000;
    end
  end
  assign ve_out = ve_q;
  assign guard_out = guard_q;
  assign err_out = err_q;
  assign {ctrl_red_out, ctrl_green_out} = ctl_q;
`else
  always_comb state_d = act_tap ? VIDEO : CTRL;
  always_ff @(posedge clk_in) state_q <= !rst_n_in ? CTRL : state_d;
  assign ve_out = (state_q == VIDEO) & act_d;
  assign guard_out = 1'b0;
  assign err_out = 1'b0;
  assign ctrl_green_out = 2'b00;
  assign ctrl_red_out = 2'b00;
`endif
endmodule
